// File: rtl/imm_narrower.sv
// Purpose: narrows a 16-bit immediate to the fewest bytes (1 or 2) that reproduce it under the
//          selected signed/unsigned extension rule, low byte first, and counts short/long words.
// Latency: input handshake at edge N -> first byte valid in the next cycle; one word per 2 (short) / 3 (long) cycles.
// Backpressure: in_ready only in IDLE; the presented byte and its flags hold stable until out_ready is seen.
//
// Ports:
//   clk, rst_n                   - clock (rising edge), asynchronous active-low reset
//   in_word, in_signed, in_valid - word to narrow, extension mode, qualifier
//   in_ready                     - block can accept a word (IDLE only)
//   out_byte, out_last, out_short, out_valid / out_ready - emitted byte stream
//   short_cnt, long_cnt          - saturating counts of words emitted as one / two bytes
module imm_narrower (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_word,
  input  logic        in_signed,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        out_short,
  output logic [7:0]  short_cnt,
  output logic [7:0]  long_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic        fit_q, fit_d;
  logic [7:0]  short_cnt_q, short_cnt_d;
  logic [7:0]  long_cnt_q, long_cnt_d;

  logic in_hs;
  logic out_hs;
  logic fit_now;

  // Signed: bits [15:7] must all equal the sign so that sign-extending the low byte
  // rebuilds the word. Unsigned: the high byte must be zero.
  always_comb begin
    fit_now = 1'b0;
    if (in_signed) begin
      fit_now = (&in_word[15:7]) | (~|in_word[15:7]);
    end else begin
      fit_now = ~|in_word[15:8];
    end
  end

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // Outputs are decoded from registered state only, so they are stable while stalled
  // and forced to zero whenever nothing is being presented.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    out_last  = 1'b0;
    out_short = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_LO: begin
        out_valid = 1'b1;
        out_byte  = word_q[7:0];
        out_last  = fit_q;
        out_short = fit_q;
      end
      ST_HI: begin
        out_valid = 1'b1;
        out_byte  = word_q[15:8];
        out_last  = 1'b1;
        out_short = 1'b0;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Next-state logic: the word and its fit flag are captured only on the input
  // handshake, so in_word activity at any other time is irrelevant.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    fit_d   = fit_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_hs) begin
          word_d  = in_word;
          fit_d   = fit_now;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (out_hs) begin
          state_d = fit_q ? ST_IDLE : ST_HI;
        end
      end
      ST_HI: begin
        if (out_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Counters advance only when the final byte of a word is accepted, and stick at 255.
  always_comb begin
    short_cnt_d = short_cnt_q;
    long_cnt_d  = long_cnt_q;
    if (out_hs && out_last) begin
      if (out_short) begin
        if (short_cnt_q != 8'hFF) begin
          short_cnt_d = short_cnt_q + 8'd1;
        end
      end else begin
        if (long_cnt_q != 8'hFF) begin
          long_cnt_d = long_cnt_q + 8'd1;
        end
      end
    end
  end

  // Reset drops any word in flight: state returns to IDLE so no remaining byte is shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      word_q      <= 16'h0000;
      fit_q       <= 1'b0;
      short_cnt_q <= 8'h00;
      long_cnt_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      fit_q       <= fit_d;
      short_cnt_q <= short_cnt_d;
      long_cnt_q  <= long_cnt_d;
    end
  end

  assign short_cnt = short_cnt_q;
  assign long_cnt  = long_cnt_q;

endmodule
